// File: rtl/ffo_bitmap_alloc288.sv
// 288-entry free-map allocator: highest-free-index grant into a valid/ready slot, frees return to the map.
// Optional ALLOC_BYPASS_EN: an accepted free lands directly in an empty slot when the map has nothing to grant.

module ffo288 (
  input  logic [287:0] vec,
  output logic [8:0]   idx
);
  // Highest set bit wins; 511 flags an all-zero vector.
  always_comb begin
    idx = 9'd511;
    for (int i = 0; i < 288; i++) begin
      if (vec[i]) idx = 9'(i);
    end
  end
endmodule

module ffo_bitmap_alloc288 #(
  parameter int unsigned RESV = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  input  logic       alloc_rdy,
  output logic       alloc_vld,
  output logic [8:0] alloc_idx,
  input  logic       free_vld,
  input  logic [8:0] free_idx,
  output logic [8:0] free_cnt,
  output logic       err_dblfree
);
  localparam int unsigned N  = 288;
  localparam int unsigned IW = 9;
  localparam logic [IW-1:0] NONE     = IW'(511);
  localparam logic [IW-1:0] LAST     = IW'(N - 1);
  localparam logic [N-1:0]  MAP_INIT = {N{1'b1}} << RESV;
  localparam logic [IW-1:0] CNT_INIT = IW'(N - RESV);

  logic [N-1:0]  map;
  logic [N-1:0]  map_n;
  logic          armed;
  logic [IW-1:0] ffo;
  logic          vld_n;
  logic [IW-1:0] idx_n;
  logic [IW-1:0] cnt_n;
  logic          handshake_c;
  logic          load_c;
  logic          free_ok_c;

  ffo288 u_ffo (
    .vec (map),
    .idx (ffo)
  );

  // armed holds off the first slot load by one edge after reset release
  assign handshake_c = alloc_vld & alloc_rdy;
  assign load_c      = armed & (~alloc_vld | alloc_rdy);

  // Freeable entries are exactly the ones set at reset; the slot entry is never in the map.
  always_comb begin
    free_ok_c = 1'b0;
    if (free_vld && (free_idx <= LAST)) begin
      free_ok_c = MAP_INIT[free_idx] & ~map[free_idx] &
                  ~(alloc_vld & (free_idx == alloc_idx));
    end
  end

  always_comb begin
    map_n = map;
    vld_n = alloc_vld;
    idx_n = alloc_idx;
    if (load_c) begin
      if (ffo != NONE) begin
        idx_n      = ffo;
        vld_n      = 1'b1;
        map_n[ffo] = 1'b0;
      end else begin
        vld_n = 1'b0;
      end
    end
`ifdef ALLOC_BYPASS_EN
    if (free_ok_c && load_c && (ffo == NONE)) begin
      idx_n = free_idx;
      vld_n = 1'b1;
    end else if (free_ok_c) begin
      map_n[free_idx] = 1'b1;
    end
`else
    if (free_ok_c) map_n[free_idx] = 1'b1;
`endif
    cnt_n = free_cnt + IW'(free_ok_c) - IW'(handshake_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      map         <= MAP_INIT;
      armed       <= 1'b0;
      alloc_vld   <= 1'b0;
      alloc_idx   <= '0;
      free_cnt    <= CNT_INIT;
      err_dblfree <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (flush) begin
        map         <= MAP_INIT;
        alloc_vld   <= 1'b0;
        alloc_idx   <= '0;
        free_cnt    <= CNT_INIT;
        err_dblfree <= 1'b0;
      end else begin
        map         <= map_n;
        alloc_vld   <= vld_n;
        alloc_idx   <= idx_n;
        free_cnt    <= cnt_n;
        err_dblfree <= free_vld & ~free_ok_c;
      end
    end
  end
endmodule
